// File: rtl/zeroriscy_irq_arbiter.sv
// Interrupt arbiter for zero-riscy: per-line level/edge sensing, enable masking,
// fixed lowest-index priority and an ack/kill handshake towards the controller.
module zeroriscy_irq_arbiter #(
   parameter int unsigned        NUM_IRQ   = 32,
   parameter int unsigned        ID_W      = 5,
   parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic [NUM_IRQ-1:0] irq_en_i,
   input  logic               m_IE_i,
   input  logic               ctrl_ack_i,
   input  logic               ctrl_kill_i,
   output logic               irq_req_ctrl_o,
   output logic [ID_W-1:0]    irq_id_ctrl_o,
   output logic [NUM_IRQ-1:0] irq_pending_o
);

   typedef enum logic [1:0] {IDLE, IRQ_PENDING, IRQ_DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [NUM_IRQ-1:0] r_irq_q;
   logic [NUM_IRQ-1:0] r_pend_edge;
   logic [ID_W-1:0]    r_id;
   logic [NUM_IRQ-1:0] w_rise;
   logic [NUM_IRQ-1:0] w_clr;
   logic [NUM_IRQ-1:0] w_pend;
   logic [NUM_IRQ-1:0] w_elig;
   logic [ID_W-1:0]    w_sel_id;
   logic               w_any;
   logic               w_ack;
   logic               w_take;

   assign w_rise = irq_i & ~r_irq_q & EDGE_MASK;
   assign w_pend = (EDGE_MASK & r_pend_edge) | (~EDGE_MASK & irq_i);
   assign w_elig = w_pend & irq_en_i;
   assign w_any  = |w_elig;
   assign w_ack  = (r_state == IRQ_PENDING) && ctrl_ack_i;
   assign w_take = (r_state == IDLE) && m_IE_i && w_any;

   // Scan downwards so the lowest eligible index is the last one written.
   always_comb begin
      w_sel_id = '0;
      for (int unsigned k = NUM_IRQ; k > 0; k--) begin
         if (w_elig[k-1]) w_sel_id = ID_W'(k - 1);
      end
   end

   always_comb begin
      w_clr = '0;
      for (int unsigned k = 0; k < NUM_IRQ; k++) begin
         w_clr[k] = w_ack && (r_id == ID_W'(k));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq_q     <= '0;
         r_pend_edge <= '0;
         r_id        <= '0;
      end else begin
         r_irq_q     <= irq_i;
         // A fresh edge in the ack cycle survives the clear.
         r_pend_edge <= ((r_pend_edge & ~w_clr) | w_rise) & EDGE_MASK;
         if (w_take) r_id <= w_sel_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:        if (w_take) w_state_nxt = IRQ_PENDING;
         IRQ_PENDING: begin
            if (ctrl_ack_i)       w_state_nxt = IRQ_DONE;
            else if (ctrl_kill_i) w_state_nxt = IDLE;
         end
         IRQ_DONE:    w_state_nxt = IDLE;
         default:     w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      irq_req_ctrl_o = (r_state == IRQ_PENDING);
      irq_id_ctrl_o  = r_id;
      irq_pending_o  = w_pend;
   end

endmodule
